// File: rtl/combo_seq_checker.sv
// ---------------------------------------------------------------------------
// combo_seq_checker
//
// Serial 5-bit combination-entry checker. Five user bits are shifted in,
// MSB (CODE bit 4) first. On the fifth accepted bit a per-bit match vector
// ~(entry ^ CODE) is registered; it feeds downstream AND5 (all-match) and
// OR5 (any-match) gates. This block sequences the entry, times the unlock
// window and, optionally, locks out after repeated failed attempts.
//
// Optional feature macro: COMBO_LOCKOUT_EN
//   defined     : MAX_TRIES consecutive failures enter LOCKOUT (exit by rst)
//   not defined : no fail counter, no LOCKOUT state, alarm tied 0
//
// Ports
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous, active-high reset
//   bit_in       in   1  entered bit, sampled when bit_valid=1 and accepted
//   bit_valid    in   1  qualifies bit_in, one bit per high cycle
//   abort        in   1  discard a partial entry (SHIFT only)
//   match_vec    out  5  registered ~(entry ^ CODE), held until next load
//   match_valid  out  1  one-cycle pulse while match_vec is fresh (CHECK)
//   unlocked     out  1  high UNLOCK_CYCLES cycles after a correct entry
//   busy         out  1  high while bits are not accepted
//   alarm        out  1  high in LOCKOUT
// ---------------------------------------------------------------------------
module combo_seq_checker #(
    parameter logic [4:0] CODE          = 5'b10110,
    parameter int         MAX_TRIES     = 3,
    parameter int         UNLOCK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       abort,
    output logic [4:0] match_vec,
    output logic       match_valid,
    output logic       unlocked,
    output logic       busy,
    output logic       alarm
);

    localparam int                 TIMER_W    = $clog2(UNLOCK_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(UNLOCK_CYCLES - 1);

`ifdef COMBO_LOCKOUT_EN
    localparam int                FAIL_W   = $clog2(MAX_TRIES + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_CHECK, S_OPEN, S_FAIL
    } state_t;
`endif

    state_t             state, state_nxt;
    // Only the first four bits need storing; the fifth arrives on bit_in
    // in the same cycle the match vector is loaded.
    logic [3:0]         sreg;
    logic [2:0]         cnt;
    logic [TIMER_W-1:0] timer;

`ifdef COMBO_LOCKOUT_EN
    logic [FAIL_W-1:0]  fail_cnt;

    function automatic logic [FAIL_W-1:0] fail_inc_sat(input logic [FAIL_W-1:0] c);
        return (c == FAIL_MAX) ? c : c + FAIL_W'(1);
    endfunction
`endif

    function automatic logic [4:0] match_of(input logic [4:0] word);
        return ~(word ^ CODE);
    endfunction

    // Next-state and Moore outputs
    always_comb begin
        state_nxt   = state;
        match_valid = 1'b0;
        unlocked    = 1'b0;
        busy        = 1'b0;
        alarm       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bit_valid) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // abort has priority over a coincident bit
                if (abort)                             state_nxt = S_IDLE;
                else if (bit_valid && cnt == 3'd4)     state_nxt = S_CHECK;
            end
            S_CHECK: begin
                match_valid = 1'b1;
                busy        = 1'b1;
                state_nxt   = (&match_vec) ? S_OPEN : S_FAIL;
            end
            S_OPEN: begin
                unlocked = 1'b1;
                busy     = 1'b1;
                if (timer == TIMER_LAST) state_nxt = S_IDLE;
            end
            S_FAIL: begin
                busy = 1'b1;
`ifdef COMBO_LOCKOUT_EN
                state_nxt = (fail_inc_sat(fail_cnt) == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
`else
                state_nxt = S_IDLE;
`endif
            end
`ifdef COMBO_LOCKOUT_EN
            S_LOCKOUT: begin
                busy  = 1'b1;
                alarm = 1'b1;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and entry/timer/fail bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            timer     <= '0;
            match_vec <= '0;
`ifdef COMBO_LOCKOUT_EN
            fail_cnt  <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (bit_valid) begin
                        sreg <= {sreg[2:0], bit_in};
                        cnt  <= 3'd1;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        sreg <= '0;
                        cnt  <= '0;
                    end else if (bit_valid) begin
                        if (cnt == 3'd4) begin
                            match_vec <= match_of({sreg, bit_in});
                            cnt       <= '0;
                        end else begin
                            sreg <= {sreg[2:0], bit_in};
                            cnt  <= cnt + 3'd1;
                        end
                    end
                end
                S_CHECK: begin
                    // timer restarts here so OPEN always lasts exactly UNLOCK_CYCLES
                    timer <= '0;
`ifdef COMBO_LOCKOUT_EN
                    if (&match_vec) fail_cnt <= '0;
`endif
                end
                S_OPEN: begin
                    timer <= timer + TIMER_W'(1);
                end
`ifdef COMBO_LOCKOUT_EN
                S_FAIL: begin
                    fail_cnt <= fail_inc_sat(fail_cnt);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_combo_seq_checker.sv
module tb_combo_seq_checker;

    localparam logic [4:0] CODE_REF = 5'b10110;
`ifdef COMBO_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       abort;
    logic [4:0] match_vec;
    logic       match_valid;
    logic       unlocked;
    logic       busy;
    logic       alarm;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        logic [4:0] code;
        logic [4:0] exp_mv;
        int         gap;
        bit         exp_open;
    } vec_t;

    vec_t tbl[10];

    combo_seq_checker #(
        .CODE         (5'b10110),
        .MAX_TRIES    (3),
        .UNLOCK_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .abort      (abort),
        .match_vec  (match_vec),
        .match_valid(match_valid),
        .unlocked   (unlocked),
        .busy       (busy),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every match_valid pulse must consume one expected vector.
    always @(negedge clk) begin
        if (match_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("match_valid_unexpected", 32'(match_valid), 32'd0);
            else                   chk("match_vec", 32'(match_vec), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_match_vec"},   32'(match_vec),   32'd0);
        chk({tag, "_match_valid"}, 32'(match_valid), 32'd0);
        chk({tag, "_unlocked"},    32'(unlocked),    32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_alarm"},       32'(alarm),       32'd0);
    endtask

    task automatic send_bits(input logic [4:0] code, input int nbits);
        for (int i = 4; i > 4 - nbits; i--) begin
            bit_in    = code[i];
            bit_valid = 1'b1;
            tick();
            bit_valid = 1'b0;
        end
    endtask

    // Drives all five bits; returns in cycle N+1.
    task automatic enter(input logic [4:0] code, input logic [4:0] exp_mv, input int gap,
                         input bit push, input bit abort_first);
        for (int i = 4; i >= 0; i--) begin
            bit_in    = code[i];
            bit_valid = 1'b1;
            abort     = abort_first && (i == 4);
            if (i == 0 && push) exp_q.push_back(exp_mv);
            tick();
            bit_valid = 1'b0;
            abort     = 1'b0;
            if (i != 0) repeat (gap) tick();
        end
    endtask

    // Starts in cycle N+1; leaves the bench in IDLE (or LOCKOUT).
    task automatic finish_entry(input bit exp_open, input bit exp_lock, input bit poke_open);
        chk("match_valid_check", 32'(match_valid), 32'd1);
        chk("busy_check",        32'(busy),        32'd1);
        chk("unlocked_check",    32'(unlocked),    32'd0);
        tick();
        if (exp_open) begin
            for (int k = 0; k < 8; k++) begin
                chk("unlocked_open",    32'(unlocked),    32'd1);
                chk("busy_open",        32'(busy),        32'd1);
                chk("match_valid_open", 32'(match_valid), 32'd0);
                if (poke_open && k < 7) begin
                    bit_valid = 1'b1;
                    bit_in    = k[0];
                    abort     = k[1];
                end else begin
                    bit_valid = 1'b0;
                    abort     = 1'b0;
                end
                tick();
            end
            bit_valid = 1'b0;
            abort     = 1'b0;
            chk("unlocked_end", 32'(unlocked), 32'd0);
            chk("busy_end",     32'(busy),     32'd0);
        end else begin
            chk("busy_fail",        32'(busy),        32'd1);
            chk("unlocked_fail",    32'(unlocked),    32'd0);
            chk("match_valid_fail", 32'(match_valid), 32'd0);
            chk("alarm_fail",       32'(alarm),       32'd0);
            tick();
            chk("alarm_after_fail", 32'(alarm), 32'(exp_lock));
            chk("busy_after_fail",  32'(busy),  32'(exp_lock));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{5'b10110, 5'b11111, 0, 1'b1};
        tbl[1] = '{5'b10111, 5'b11110, 0, 1'b0};
        tbl[2] = '{5'b10110, 5'b11111, 2, 1'b1};
        tbl[3] = '{5'b01001, 5'b00000, 0, 1'b0};
        tbl[4] = '{5'b10110, 5'b11111, 1, 1'b1};
        tbl[5] = '{5'b00110, 5'b01111, 0, 1'b0};
        tbl[6] = '{5'b10100, 5'b11101, 0, 1'b0};
        tbl[7] = '{5'b10110, 5'b11111, 0, 1'b1};
        tbl[8] = '{5'b11111, 5'b10110, 3, 1'b0};
        tbl[9] = '{5'b10110, 5'b11111, 0, 1'b1};

        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0;
        tick();
        tick();
        check_cleared("reset");
        rst = 1'b0;

        // Table-driven entries, including gapped bit_valid
        for (int i = 0; i < 10; i++) begin
            enter(tbl[i].code, tbl[i].exp_mv, tbl[i].gap, 1'b1, 1'b0);
            finish_entry(tbl[i].exp_open, 1'b0, 1'b0);
            chk("match_vec_hold", 32'(match_vec), 32'(tbl[i].exp_mv));
        end

        // Abort after three bits, then a correct entry
        send_bits(5'b10110, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        enter(CODE_REF, 5'b11111, 0, 1'b1, 1'b0);
        finish_entry(1'b1, 1'b0, 1'b0);

        // Abort coincident with the fifth bit: bit discarded, no pulse
        send_bits(5'b10110, 4);
        bit_in = 1'b0; bit_valid = 1'b1; abort = 1'b1;
        tick();
        bit_valid = 1'b0; abort = 1'b0;
        chk("abort5_match_valid", 32'(match_valid), 32'd0);
        chk("abort5_busy",        32'(busy),        32'd0);
        tick();
        chk("abort5_match_valid2", 32'(match_valid), 32'd0);
        chk("abort5_mv_hold",      32'(match_vec),   32'h1f);
        // Counter must have restarted: a full five-bit entry is needed
        enter(5'b10111, 5'b11110, 0, 1'b1, 1'b0);
        finish_entry(1'b0, 1'b0, 1'b0);

        // abort in IDLE is ignored; bit_valid/abort pokes during OPEN are dropped
        enter(CODE_REF, 5'b11111, 0, 1'b1, 1'b1);
        finish_entry(1'b1, 1'b0, 1'b1);
        enter(CODE_REF, 5'b11111, 0, 1'b1, 1'b0);
        finish_entry(1'b1, 1'b0, 1'b0);

        // rst during SHIFT
        send_bits(5'b10110, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("rst_shift");
        enter(5'b11111, 5'b10110, 0, 1'b1, 1'b0);
        finish_entry(1'b0, 1'b0, 1'b0);

        // rst during OPEN
        enter(CODE_REF, 5'b11111, 0, 1'b1, 1'b0);
        chk("rst_open_pulse", 32'(match_valid), 32'd1);
        tick();
        tick();
        chk("rst_open_unlocked", 32'(unlocked), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("rst_open");

        // Fail counting: clears on success, trips on the third consecutive failure
        enter(5'b00000, 5'b01001, 0, 1'b1, 1'b0);
        finish_entry(1'b0, 1'b0, 1'b0);
        enter(5'b00000, 5'b01001, 0, 1'b1, 1'b0);
        finish_entry(1'b0, 1'b0, 1'b0);
        enter(CODE_REF, 5'b11111, 0, 1'b1, 1'b0);
        finish_entry(1'b1, 1'b0, 1'b0);
        enter(5'b10111, 5'b11110, 0, 1'b1, 1'b0);
        finish_entry(1'b0, 1'b0, 1'b0);
        enter(5'b00110, 5'b01111, 0, 1'b1, 1'b0);
        finish_entry(1'b0, 1'b0, 1'b0);
        enter(5'b00000, 5'b01001, 0, 1'b1, 1'b0);
        finish_entry(1'b0, LOCK_EN, 1'b0);
`ifdef COMBO_LOCKOUT_EN
        // Correct entry while locked out is ignored
        enter(CODE_REF, 5'b11111, 0, 1'b0, 1'b0);
        chk("lock_match_valid", 32'(match_valid), 32'd0);
        chk("lock_alarm",       32'(alarm),       32'd1);
        tick();
        chk("lock_unlocked", 32'(unlocked), 32'd0);
        chk("lock_busy",     32'(busy),     32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("rst_lockout");
`else
        // Unlimited retries: the fourth (correct) entry unlocks
        enter(CODE_REF, 5'b11111, 0, 1'b1, 1'b0);
        finish_entry(1'b1, 1'b0, 1'b0);
        chk("no_lock_alarm", 32'(alarm), 32'd0);
`endif

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
